// File: rtl/sprite_palette_lut_pkg.sv
// ---------------------------------------------------------------------------
// sprite_palette_lut_pkg
//   Shared types and constants for the sprite palette lookup.
//   - rgb565_t      : 16-bit RGB565 pixel
//   - TRANSP_COLOR  : chroma-key colour reported as transparent
//   - pal_state_e   : fill / ready state of the lookup
//   - fade_rgb565() : per-channel brightness scaling, used when the design is
//                     built with PALETTE_FADE_EN defined
// ---------------------------------------------------------------------------
package sprite_palette_lut_pkg;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t TRANSP_COLOR = 16'h07E0;

  typedef enum logic [0:0] {
    PAL_INIT  = 1'b0,
    PAL_READY = 1'b1
  } pal_state_e;

  // Scale each channel by (lvl+1)/16; lvl=15 multiplies by exactly 1.
  // Products never exceed channel_max*16, so the shifted value fits the channel.
  function automatic rgb565_t fade_rgb565(input rgb565_t c, input logic [3:0] lvl);
    logic [4:0]  mul;
    logic [9:0]  r_p;
    logic [10:0] g_p;
    logic [9:0]  b_p;
    mul = {1'b0, lvl} + 5'd1;
    r_p = 10'(c[15:11]) * 10'(mul);
    g_p = 11'(c[10:5])  * 11'(mul);
    b_p = 10'(c[4:0])   * 10'(mul);
    return {5'(r_p >> 4), 6'(g_p >> 4), 5'(b_p >> 4)};
  endfunction

endpackage

// File: rtl/sprite_palette_lut_ram.sv
// ---------------------------------------------------------------------------
// sprite_palette_lut_ram
//   Simple dual-port (1 write / 1 read) synchronous RAM, DEPTH x DATA_W.
//   A read and a write to the same address in one cycle return the OLD data.
//   Written so that synthesis maps it onto a block RAM (no reset on storage).
// Ports:
//   clk_i                     clock
//   we_i, waddr_i, wdata_i    write port
//   re_i, raddr_i             read request; rdata_o is valid one cycle later
//   rdata_o                   registered read data (holds when re_i is low)
// ---------------------------------------------------------------------------
module sprite_palette_lut_ram
  import sprite_palette_lut_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; non-blocking update gives read-old on collision.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_palette_lut.sv
// ---------------------------------------------------------------------------
// sprite_palette_lut
//   Multi-bank runtime-writable palette lookup: (palette, index) -> RGB565.
//   After reset every entry is filled with 16'h0000, except the last index of
//   each bank which gets TRANSP_COLOR; init_done rises when the fill is done.
//   Lookups are fully pipelined, one per cycle, fixed latency 2
//   (3 with the optional fade stage).
// Configuration macro:
//   PALETTE_FADE_EN  adds the fade_level port and a brightness-scaling stage.
// Ports:
//   Clk, Reset_n                         clock, asynchronous active-low reset
//   rd_valid, rd_pal, rd_idx             lookup request
//   out_valid, out_color, out_transp     lookup result (held when out_valid=0)
//   wr_en, wr_pal, wr_idx, wr_color      palette write port (ignored during fill)
//   init_done                            high once the default fill completed
//   fade_level                           brightness 0..15, 15 = full (fade build only)
// ---------------------------------------------------------------------------
module sprite_palette_lut
  import sprite_palette_lut_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int PAL_W = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             rd_valid,
  input  logic [PAL_W-1:0] rd_pal,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             out_valid,
  output logic [15:0]      out_color,
  output logic             out_transp,
  input  logic             wr_en,
  input  logic [PAL_W-1:0] wr_pal,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [15:0]      wr_color,
  output logic             init_done
`ifdef PALETTE_FADE_EN
  ,
  input  logic [3:0]       fade_level
`endif
);

  localparam int ADDR_W = IDX_W + PAL_W;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int CNT_W  = ADDR_W + 1;

  pal_state_e       state_q, state_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             init_done_q;

  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_waddr_s;
  rgb565_t           ram_wdata_s;
  rgb565_t           ram_rdata_s;
  logic [ADDR_W-1:0] fill_addr_s;
  logic              rd_accept_s;

  logic    v1_q;
  logic    v2_q;
  rgb565_t c2_q;
  logic    t2_q;

  // Fill sequencer next state: one entry per cycle, then READY forever.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    case (state_q)
      PAL_INIT: begin
        fill_d = fill_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (fill_q == CNT_W'(DEPTH - 1)) begin
          state_d = PAL_READY;
        end else begin
          state_d = PAL_INIT;
        end
      end
      PAL_READY: begin
        state_d = PAL_READY;
      end
      default: begin
        state_d = PAL_INIT;
      end
    endcase
  end

  // Fill sequencer state, fill counter and init_done flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= PAL_INIT;
      fill_q      <= {CNT_W{1'b0}};
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      init_done_q <= (state_d == PAL_READY);
    end
  end

  assign fill_addr_s = fill_q[ADDR_W-1:0];

  // RAM write mux: the fill owns the port during INIT, user writes are dropped.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = {ADDR_W{1'b0}};
    ram_wdata_s = 16'h0000;
    if (state_q == PAL_INIT) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = fill_addr_s;
      // Last index of every bank defaults to the chroma key.
      if (&fill_addr_s[IDX_W-1:0]) begin
        ram_wdata_s = TRANSP_COLOR;
      end else begin
        ram_wdata_s = 16'h0000;
      end
    end else begin
      ram_we_s    = wr_en;
      ram_waddr_s = {wr_pal, wr_idx};
      ram_wdata_s = wr_color;
    end
  end

  assign rd_accept_s = rd_valid && (state_q == PAL_READY);

  sprite_palette_lut_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (16)
  ) u_ram (
    .clk_i   (Clk),
    .we_i    (ram_we_s),
    .waddr_i (ram_waddr_s),
    .wdata_i (ram_wdata_s),
    .re_i    (rd_accept_s),
    .raddr_i ({rd_pal, rd_idx}),
    .rdata_o (ram_rdata_s)
  );

  // S1 valid tracks the RAM read register; S2 captures colour and key flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      c2_q <= 16'h0000;
      t2_q <= 1'b0;
    end else begin
      v1_q <= rd_accept_s;
      v2_q <= v1_q;
      if (v1_q) begin
        c2_q <= ram_rdata_s;
        t2_q <= (ram_rdata_s == TRANSP_COLOR);
      end
    end
  end

`ifdef PALETTE_FADE_EN
  logic    v3_q;
  rgb565_t c3_q;
  logic    t3_q;

  // S3 fade stage; transparency was decided on the unfaded colour in S2.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      v3_q <= 1'b0;
      c3_q <= 16'h0000;
      t3_q <= 1'b0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) begin
        c3_q <= fade_rgb565(c2_q, fade_level);
        t3_q <= t2_q;
      end
    end
  end

  assign out_valid  = v3_q;
  assign out_color  = c3_q;
  assign out_transp = t3_q;
`else
  assign out_valid  = v2_q;
  assign out_color  = c2_q;
  assign out_transp = t2_q;
`endif

  assign init_done = init_done_q;

endmodule
